// File: rtl/decode_pkg.sv
// Shared types, opcode/funct constants and small decode helpers for the
// RV32IM decode queue.
package decode_pkg;

  typedef enum logic [4:0] {
    ALU_ADD, ALU_SUB, ALU_SLL, ALU_SLT, ALU_SLTU, ALU_XOR, ALU_SRL, ALU_SRA,
    ALU_OR, ALU_AND, ALU_PASSB, ALU_MUL, ALU_MULH, ALU_MULHSU, ALU_MULHU,
    ALU_DIV, ALU_DIVU, ALU_REM, ALU_REMU
  } alu_op_e;

  typedef enum logic [2:0] {
    BRU_NONE, BRU_BEQ, BRU_BNE, BRU_BLT, BRU_BGE, BRU_BLTU, BRU_BGEU, BRU_JAL
  } bru_op_e;

  typedef enum logic [3:0] {
    MEM_NONE, MEM_LB, MEM_LH, MEM_LW, MEM_LBU, MEM_LHU, MEM_SB, MEM_SH, MEM_SW
  } mem_op_e;

  typedef enum logic [1:0] {
    REG = 2'd0, IMM = 2'd1, PC_JAL = 2'd2, PC_AUIPC = 2'd3
  } alu_src_e;

  typedef struct packed {
    logic     jalr;
    bru_op_e  bru_op;
    alu_op_e  alu_op;
    alu_src_e alu_src;
    mem_op_e  mem_op;
    logic     mem_write;
    logic     mem_read;
    logic     reg_write;
    logic     mem_to_reg;
  } ctrl_t;

  localparam logic [6:0] OPC_LUI    = 7'h37;
  localparam logic [6:0] OPC_AUIPC  = 7'h17;
  localparam logic [6:0] OPC_JAL    = 7'h6F;
  localparam logic [6:0] OPC_JALR   = 7'h67;
  localparam logic [6:0] OPC_BRANCH = 7'h63;
  localparam logic [6:0] OPC_LOAD   = 7'h03;
  localparam logic [6:0] OPC_STORE  = 7'h23;
  localparam logic [6:0] OPC_OP_IMM = 7'h13;
  localparam logic [6:0] OPC_OP     = 7'h33;
  localparam logic [6:0] OPC_SYSTEM = 7'h73;

  localparam logic [2:0] F3_ADD = 3'd0;
  localparam logic [2:0] F3_SLL = 3'd1;
  localparam logic [2:0] F3_SR  = 3'd5;

  localparam logic [6:0] F7_BASE   = 7'h00;
  localparam logic [6:0] F7_ALT    = 7'h20;
  localparam logic [6:0] F7_MULDIV = 7'h01;

  localparam logic [31:0] ECALL_INST = 32'h0000_0073;

  function automatic alu_op_e base_alu_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_ADD;
      3'd1:    return ALU_SLL;
      3'd2:    return ALU_SLT;
      3'd3:    return ALU_SLTU;
      3'd4:    return ALU_XOR;
      3'd5:    return ALU_SRL;
      3'd6:    return ALU_OR;
      default: return ALU_AND;
    endcase
  endfunction

  function automatic alu_op_e muldiv_alu_op(input logic [2:0] f3);
    case (f3)
      3'd0:    return ALU_MUL;
      3'd1:    return ALU_MULH;
      3'd2:    return ALU_MULHSU;
      3'd3:    return ALU_MULHU;
      3'd4:    return ALU_DIV;
      3'd5:    return ALU_DIVU;
      3'd6:    return ALU_REM;
      default: return ALU_REMU;
    endcase
  endfunction

endpackage

// File: rtl/ctrl_decode.sv
// Combinational RV32IM decoder: raw instruction to control bundle, with an
// illegal flag that forces the bundle to zero.
module ctrl_decode
  import decode_pkg::*;
#(
  parameter bit EN_M = 1'b1
) (
  input  logic [31:0] inst_i,
  output ctrl_t       ctrl_o,
  output logic        illegal_o
);

  logic [6:0] opcode;
  logic [6:0] funct7;
  logic [2:0] funct3;
  ctrl_t      ctrl;
  logic       ill;

  assign opcode = inst_i[6:0];
  assign funct3 = inst_i[14:12];
  assign funct7 = inst_i[31:25];

  always_comb begin
    ctrl = '0;
    ill  = 1'b0;
    case (opcode)
      OPC_LUI: begin
        ctrl.alu_op    = ALU_PASSB;
        ctrl.alu_src   = IMM;
        ctrl.reg_write = 1'b1;
      end
      OPC_AUIPC: begin
        ctrl.alu_src   = PC_AUIPC;
        ctrl.reg_write = 1'b1;
      end
      OPC_JAL: begin
        ctrl.bru_op    = BRU_JAL;
        ctrl.alu_src   = PC_JAL;
        ctrl.reg_write = 1'b1;
      end
      OPC_JALR: begin
        ctrl.jalr      = 1'b1;
        ctrl.alu_src   = PC_JAL;
        ctrl.reg_write = 1'b1;
        ill            = (funct3 != 3'd0);
      end
      OPC_BRANCH: begin
        ctrl.alu_op = ALU_SUB;
        case (funct3)
          3'd0:    ctrl.bru_op = BRU_BEQ;
          3'd1:    ctrl.bru_op = BRU_BNE;
          3'd4:    ctrl.bru_op = BRU_BLT;
          3'd5:    ctrl.bru_op = BRU_BGE;
          3'd6:    ctrl.bru_op = BRU_BLTU;
          3'd7:    ctrl.bru_op = BRU_BGEU;
          default: ill = 1'b1;
        endcase
      end
      OPC_LOAD: begin
        ctrl.alu_src    = IMM;
        ctrl.mem_read   = 1'b1;
        ctrl.reg_write  = 1'b1;
        ctrl.mem_to_reg = 1'b1;
        case (funct3)
          3'd0:    ctrl.mem_op = MEM_LB;
          3'd1:    ctrl.mem_op = MEM_LH;
          3'd2:    ctrl.mem_op = MEM_LW;
          3'd4:    ctrl.mem_op = MEM_LBU;
          3'd5:    ctrl.mem_op = MEM_LHU;
          default: ill = 1'b1;
        endcase
      end
      OPC_STORE: begin
        ctrl.alu_src   = IMM;
        ctrl.mem_write = 1'b1;
        case (funct3)
          3'd0:    ctrl.mem_op = MEM_SB;
          3'd1:    ctrl.mem_op = MEM_SH;
          3'd2:    ctrl.mem_op = MEM_SW;
          default: ill = 1'b1;
        endcase
      end
      OPC_OP_IMM: begin
        ctrl.alu_src   = IMM;
        ctrl.reg_write = 1'b1;
        ctrl.alu_op    = base_alu_op(funct3);
        // Shift immediates reuse funct7 to pick logical vs arithmetic.
        if (funct3 == F3_SLL) begin
          ill = (funct7 != F7_BASE);
        end else if (funct3 == F3_SR) begin
          if (funct7 == F7_ALT) ctrl.alu_op = ALU_SRA;
          else                  ill = (funct7 != F7_BASE);
        end
      end
      OPC_OP: begin
        ctrl.reg_write = 1'b1;
        case (funct7)
          F7_BASE: ctrl.alu_op = base_alu_op(funct3);
          F7_ALT: begin
            if (funct3 == F3_ADD)     ctrl.alu_op = ALU_SUB;
            else if (funct3 == F3_SR) ctrl.alu_op = ALU_SRA;
            else                      ill = 1'b1;
          end
          F7_MULDIV: begin
            if (EN_M) ctrl.alu_op = muldiv_alu_op(funct3);
            else      ill = 1'b1;
          end
          default: ill = 1'b1;
        endcase
      end
      OPC_SYSTEM: ill = (inst_i != ECALL_INST);
      default:    ill = 1'b1;
    endcase
  end

  assign ctrl_o    = ill ? '0 : ctrl;
  assign illegal_o = ill;

endmodule

// File: rtl/decode_queue.sv
// Decode stage with a DEPTH-entry FIFO towards EX, flush support and ECALL
// serialisation against an external completion pulse.
module decode_queue
  import decode_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int XLEN  = 32,
  parameter bit EN_M  = 1'b1
) (
  input  logic            clk,
  input  logic            rst_n,
  input  logic            flush,
  input  logic            in_valid,
  output logic            in_ready,
  input  logic [XLEN-1:0] in_inst,
  input  logic [XLEN-1:0] in_pc,
  output logic            out_valid,
  input  logic            out_ready,
  output ctrl_t           out_ctrl,
  output logic [XLEN-1:0] out_inst,
  output logic [XLEN-1:0] out_pc,
  output logic            out_illegal,
  input  logic            sys_done,
  output logic            sys_busy
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam int CNT_W = PTR_W + 1;

  ctrl_t dec_ctrl;
  logic  dec_illegal;

  ctrl_decode #(.EN_M(EN_M)) u_ctrl_decode (
    .inst_i    (in_inst[31:0]),
    .ctrl_o    (dec_ctrl),
    .illegal_o (dec_illegal)
  );

  ctrl_t           ctrl_mem_q [DEPTH];
  logic [XLEN-1:0] inst_mem_q [DEPTH];
  logic [XLEN-1:0] pc_mem_q   [DEPTH];
  logic            ill_mem_q  [DEPTH];

  logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
  logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             busy_q, busy_d;
  logic             have_head, push, pop, head_is_ecall;

  // in_ready looks only at registered count and flush, never at out_ready.
  assign have_head     = (count_q != '0);
  assign in_ready      = (count_q < CNT_W'(DEPTH)) && !flush;
  assign out_valid     = have_head && !busy_q;
  assign push          = in_valid && in_ready;
  assign pop           = out_valid && out_ready && !flush;
  assign head_is_ecall = (inst_mem_q[rd_ptr_q] == XLEN'(ECALL_INST));
  assign sys_busy      = busy_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    count_d  = count_q;
    busy_d   = busy_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      count_d  = '0;
      busy_d   = 1'b0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + PTR_W'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + PTR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
      if (pop && head_is_ecall) busy_d = 1'b1;
      else if (sys_done)        busy_d = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      busy_q   <= 1'b0;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      busy_q   <= busy_d;
    end
  end

  // Storage is not reset; outputs are masked to zero while the FIFO is empty.
  always_ff @(posedge clk) begin
    if (push) begin
      ctrl_mem_q[wr_ptr_q] <= dec_ctrl;
      inst_mem_q[wr_ptr_q] <= in_inst;
      pc_mem_q[wr_ptr_q]   <= in_pc;
      ill_mem_q[wr_ptr_q]  <= dec_illegal;
    end
  end

  assign out_ctrl    = have_head ? ctrl_mem_q[rd_ptr_q] : '0;
  assign out_inst    = have_head ? inst_mem_q[rd_ptr_q] : '0;
  assign out_pc      = have_head ? pc_mem_q[rd_ptr_q]   : '0;
  assign out_illegal = have_head && ill_mem_q[rd_ptr_q];

endmodule
